// File: rtl/cmul_join_sat_pkg.sv
// Shared sc16 field layout, saturation limits and helpers for the
// cmul_join_sat complex multiplier stage.
package cmul_join_sat_pkg;

   localparam int SC16_I_MSB   = 31;
   localparam int SC16_I_LSB   = 16;
   localparam int SC16_Q_MSB   = 15;
   localparam int SC16_Q_LSB   = 0;
   localparam int PIPE_LATENCY = 4;

   localparam logic signed [15:0] SC16_MAX = 16'sh7FFF;
   localparam logic signed [15:0] SC16_MIN = 16'sh8000;
   localparam logic signed [32:0] SAT_HI   = 33'sd32767;
   localparam logic signed [32:0] SAT_LO   = -33'sd32768;

   function automatic logic signed [15:0] sc16_i(input logic [31:0] s);
      return s[SC16_I_MSB:SC16_I_LSB];
   endfunction

   function automatic logic signed [15:0] sc16_q(input logic [31:0] s);
      return s[SC16_Q_MSB:SC16_Q_LSB];
   endfunction

   function automatic logic signed [31:0] mul16(input logic signed [15:0] x,
                                                input logic signed [15:0] y);
      return $signed({{16{x[15]}}, x}) * $signed({{16{y[15]}}, y});
   endfunction

   function automatic logic signed [32:0] ext33(input logic signed [31:0] x);
      return {x[31], x};
   endfunction

   // Clamp an already-scaled value into the sc16 range.
   function automatic logic [15:0] sat16(input logic signed [32:0] v);
      logic [15:0] r;
      if (v > SAT_HI) begin
         r = SC16_MAX;
      end else if (v < SAT_LO) begin
         r = SC16_MIN;
      end else begin
         r = v[15:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/cmul_sat_core.sv
// Fixed four-stage complex multiply / round / saturate pipeline; never stalls,
// a valid and last bit travel alongside each stage.
module cmul_sat_core
   import cmul_join_sat_pkg::*;
#(
   parameter int SHIFT = 15
) (
   input  logic        clk,
   input  logic        flush_i,
   input  logic        valid_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        last_i,
   output logic        valid_o,
   output logic [31:0] data_o,
   output logic        last_o
);

   localparam logic signed [32:0] ROUND = 33'sd1 <<< (SHIFT - 1);

   logic [3:0]         vld_q;
   logic [3:0]         last_q;
   logic signed [15:0] ar_q, ai_q, br_q, bi_q;
   logic signed [31:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
   logic signed [32:0] re_q, im_q;
   logic [31:0]        data_q;

   // Stage valids are flushed; last rides along unreset and is qualified later.
   always_ff @(posedge clk) begin
      if (flush_i) begin
         vld_q <= 4'b0000;
      end else begin
         vld_q <= {vld_q[2:0], valid_i};
      end
      last_q <= {last_q[2:0], last_i};
   end

   // S1 capture, S2 products, S3 sums plus half-LSB, S4 shift and clamp.
   always_ff @(posedge clk) begin
      ar_q   <= sc16_i(a_i);
      ai_q   <= sc16_q(a_i);
      br_q   <= sc16_i(b_i);
      bi_q   <= sc16_q(b_i);
      p_rr_q <= mul16(ar_q, br_q);
      p_ii_q <= mul16(ai_q, bi_q);
      p_ri_q <= mul16(ar_q, bi_q);
      p_ir_q <= mul16(ai_q, br_q);
      re_q   <= ext33(p_rr_q) - ext33(p_ii_q) + ROUND;
      im_q   <= ext33(p_ri_q) + ext33(p_ir_q) + ROUND;
      data_q <= {sat16(re_q >>> SHIFT), sat16(im_q >>> SHIFT)};
   end

   assign valid_o = vld_q[3];
   assign last_o  = last_q[3];
   assign data_o  = data_q;

endmodule

// File: rtl/cmul_join_sat.sv
// Joins the A and B sc16 streams pairwise, multiplies them, and buffers the
// results in a credit-counted FIFO so the pipeline never has to stall.
module cmul_join_sat
   import cmul_join_sat_pkg::*;
#(
   parameter int SHIFT     = 15,
   parameter int FIFO_SIZE = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [31:0] a_tdata,
   input  logic        a_tlast,
   input  logic        a_tvalid,
   output logic        a_tready,
   input  logic [31:0] b_tdata,
   input  logic        b_tlast,
   input  logic        b_tvalid,
   output logic        b_tready,
   output logic [31:0] o_tdata,
   output logic        o_tlast,
   output logic        o_tvalid,
   input  logic        o_tready,
   output logic        last_mismatch
);

   localparam logic [FIFO_SIZE:0] DEPTH = {1'b1, {FIFO_SIZE{1'b0}}};
   localparam logic [FIFO_SIZE:0] ONE   = {{FIFO_SIZE{1'b0}}, 1'b1};
   localparam logic [FIFO_SIZE:0] ZERO  = {(FIFO_SIZE + 1){1'b0}};

   logic                 flush_s, space_s, accept_s, pop_s;
   logic [FIFO_SIZE:0]   credit_q, credit_d, wr_ptr_q, rd_ptr_q;
   logic                 last_mismatch_q;
   logic                 core_valid_s, core_last_s;
   logic [31:0]          core_data_s;
   logic [32:0]          mem_q [0:(1 << FIFO_SIZE) - 1];
   logic [32:0]          head_s;

   // Credit covers every sample in the pipeline and the FIFO, so readiness
   // never depends on o_tready in the same cycle.
   assign flush_s  = reset | clear;
   assign space_s  = (credit_q < DEPTH);
   assign a_tready = b_tvalid & space_s & ~flush_s;
   assign b_tready = a_tvalid & space_s & ~flush_s;
   assign accept_s = a_tvalid & b_tvalid & space_s & ~flush_s;
   assign pop_s    = o_tvalid & o_tready;

   // Next credit value from accept/pop.
   always_comb begin
      credit_d = credit_q;
      case ({accept_s, pop_s})
         2'b10:   credit_d = credit_q + ONE;
         2'b01:   credit_d = credit_q - ONE;
         default: credit_d = credit_q;
      endcase
   end

   // Control state: credit, FIFO pointers, mismatch pulse.
   always_ff @(posedge clk) begin
      if (flush_s) begin
         credit_q        <= ZERO;
         wr_ptr_q        <= ZERO;
         rd_ptr_q        <= ZERO;
         last_mismatch_q <= 1'b0;
      end else begin
         credit_q        <= credit_d;
         wr_ptr_q        <= core_valid_s ? (wr_ptr_q + ONE) : wr_ptr_q;
         rd_ptr_q        <= pop_s ? (rd_ptr_q + ONE) : rd_ptr_q;
         last_mismatch_q <= accept_s & (a_tlast ^ b_tlast);
      end
   end

   cmul_sat_core #(
      .SHIFT (SHIFT)
   ) u_core (
      .clk     (clk),
      .flush_i (flush_s),
      .valid_i (accept_s),
      .a_i     (a_tdata),
      .b_i     (b_tdata),
      .last_i  (a_tlast),
      .valid_o (core_valid_s),
      .data_o  (core_data_s),
      .last_o  (core_last_s)
   );

   // FIFO storage; contents are not reset, only the pointers are.
   always_ff @(posedge clk) begin
      if (core_valid_s) begin
         mem_q[wr_ptr_q[FIFO_SIZE-1:0]] <= {core_last_s, core_data_s};
      end else begin
         mem_q[wr_ptr_q[FIFO_SIZE-1:0]] <= mem_q[wr_ptr_q[FIFO_SIZE-1:0]];
      end
   end

   assign head_s        = mem_q[rd_ptr_q[FIFO_SIZE-1:0]];
   assign o_tvalid      = (wr_ptr_q != rd_ptr_q);
   assign o_tdata       = head_s[31:0];
   assign o_tlast       = o_tvalid & head_s[32];
   assign last_mismatch = last_mismatch_q;

endmodule
